// File: rtl/cpu_pkg.sv
// Shared hazard-tracking types and forwarding-select width helper.
package cpu_pkg;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } hz_entry_t;

  // Forwarding select width for the default pipeline depth; 0 means register file.
  localparam int HZ_DEPTH = 2;
  localparam int FWD_W    = $clog2(HZ_DEPTH + 1);

  // Same width rule for any depth, used by modules whose DEPTH is overridden.
  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_port.sv
// Priority match and operand mux for one source-operand read port.
module hazard_fwd_port #(
  parameter int DEPTH      = 2,
  parameter int XLEN       = 32,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_W      = 2
) (
  input  logic [4:0]                 i_rs_addr,
  input  logic [DEPTH-1:0]           i_stg_vld,
  input  logic [DEPTH-1:0][4:0]      i_stg_rd,
  input  logic [DEPTH-1:0]           i_stg_ld,
  input  logic [DEPTH-1:0][XLEN-1:0] i_stage_wdata,
  input  logic [XLEN-1:0]            i_rf_rdata,
  output logic [FWD_W-1:0]           o_fwd_sel,
  output logic [XLEN-1:0]            o_rs_data,
  output logic                       o_load_hz
);

  int   hit_k;
  logic hit_ld;

  // Scan oldest to youngest so the youngest (smallest k) match overwrites older ones.
  always_comb begin
    o_fwd_sel = '0;
    o_rs_data = i_rf_rdata;
    hit_k     = 0;
    hit_ld    = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_stg_vld[k-1] && (i_stg_rd[k-1] != 5'd0) && (i_stg_rd[k-1] == i_rs_addr)) begin
        o_fwd_sel = FWD_W'(k);
        o_rs_data = i_stage_wdata[k-1];
        hit_k     = k;
        hit_ld    = i_stg_ld[k-1];
      end
    end
    // A load result is not ready until it reaches LOAD_STAGE.
    o_load_hz = hit_ld && (hit_k < LOAD_STAGE);
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard tracker: forwarding selection, load-use stall, stall counter.
module hazard_unit #(
  parameter  int DEPTH      = 2,
  parameter  int NREAD      = 2,
  parameter  int LOAD_STAGE = 2,
  parameter  int XLEN       = 32,
  localparam int FWD_W      = cpu_pkg::fwd_w(DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_issue_valid,
  input  logic [4:0]                  i_issue_rd,
  input  logic                        i_issue_is_load,
  input  logic [NREAD-1:0][4:0]       i_issue_rs_addr,
  input  logic                        i_kill,
  input  logic [NREAD-1:0][XLEN-1:0]  i_rf_rdata,
  input  logic [DEPTH-1:0][XLEN-1:0]  i_stage_wdata,
  output logic                        o_stall,
  output logic [NREAD-1:0][FWD_W-1:0] o_fwd_sel,
  output logic [NREAD-1:0][XLEN-1:0]  o_rs_data,
  output logic [31:0]                 o_stall_count
);
  import cpu_pkg::*;

  hz_entry_t [DEPTH-1:0]      stage_q, stage_d;
  logic [31:0]                stall_count_q, stall_count_d;
  logic [DEPTH-1:0]           stg_vld, stg_ld;
  logic [DEPTH-1:0][4:0]      stg_rd;
  logic [NREAD-1:0]           port_hz;
  logic                       issue_fire;

  // A kill squashes the issuing instruction, so it also cancels any stall.
  assign o_stall    = i_issue_valid && (|port_hz) && !i_kill;
  assign issue_fire = i_issue_valid && !o_stall && !i_kill;

  // Next tracking state: new entry (or bubble) enters stage 1, others shift down.
  always_comb begin
    stage_d = '0;
    if (issue_fire) begin
      stage_d[0].valid   = 1'b1;
      stage_d[0].rd      = i_issue_rd;
      stage_d[0].is_load = i_issue_is_load;
    end
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Saturating count of cycles spent stalled.
  always_comb begin
    stall_count_d = stall_count_q;
    if (o_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Tracking pipeline and stall counter; reset drops every in-flight entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q       <= '0;
      stall_count_q <= '0;
    end else begin
      stage_q       <= stage_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign o_stall_count = stall_count_q;

  // Split entries into per-field vectors for the port matchers.
  always_comb begin
    stg_vld = '0;
    stg_rd  = '0;
    stg_ld  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stg_vld[k] = stage_q[k].valid;
      stg_rd[k]  = stage_q[k].rd;
      stg_ld[k]  = stage_q[k].is_load;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    hazard_fwd_port #(
      .DEPTH      (DEPTH),
      .XLEN       (XLEN),
      .LOAD_STAGE (LOAD_STAGE),
      .FWD_W      (FWD_W)
    ) u_port (
      .i_rs_addr     (i_issue_rs_addr[p]),
      .i_stg_vld     (stg_vld),
      .i_stg_rd      (stg_rd),
      .i_stg_ld      (stg_ld),
      .i_stage_wdata (i_stage_wdata),
      .i_rf_rdata    (i_rf_rdata[p]),
      .o_fwd_sel     (o_fwd_sel[p]),
      .o_rs_data     (o_rs_data[p]),
      .o_load_hz     (port_hz[p])
    );
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench: default configuration plus a DEPTH=4/LOAD_STAGE=3 instance.
module tb_hazard_unit;

  logic clk;
  logic rst_n;

  // default instance
  logic              a_iv, a_ld, a_kill;
  logic [4:0]        a_rd;
  logic [1:0][4:0]   a_rs;
  logic [1:0][31:0]  a_rf;
  logic [1:0][31:0]  a_wd;
  logic              a_stall;
  logic [1:0][1:0]   a_sel;
  logic [1:0][31:0]  a_data;
  logic [31:0]       a_cnt;

  // deep instance
  logic              b_iv, b_ld, b_kill;
  logic [4:0]        b_rd;
  logic [1:0][4:0]   b_rs;
  logic [1:0][31:0]  b_rf;
  logic [3:0][31:0]  b_wd;
  logic              b_stall;
  logic [1:0][2:0]   b_sel;
  logic [1:0][31:0]  b_data;
  logic [31:0]       b_cnt;

  int total = 0;
  int bad   = 0;

  hazard_unit u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(a_iv), .i_issue_rd(a_rd),
    .i_issue_is_load(a_ld), .i_issue_rs_addr(a_rs), .i_kill(a_kill),
    .i_rf_rdata(a_rf), .i_stage_wdata(a_wd), .o_stall(a_stall),
    .o_fwd_sel(a_sel), .o_rs_data(a_data), .o_stall_count(a_cnt)
  );

  hazard_unit #(.DEPTH(4), .NREAD(2), .LOAD_STAGE(3), .XLEN(32)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(b_iv), .i_issue_rd(b_rd),
    .i_issue_is_load(b_ld), .i_issue_rs_addr(b_rs), .i_kill(b_kill),
    .i_rf_rdata(b_rf), .i_stage_wdata(b_wd), .o_stall(b_stall),
    .o_fwd_sel(b_sel), .o_rs_data(b_data), .o_stall_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic v, input logic [4:0] rd, input logic ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic kill);
    a_iv = v; a_rd = rd; a_ld = ld; a_rs[0] = rs0; a_rs[1] = rs1; a_kill = kill;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_rf[0] = 32'hAAAA; a_rf[1] = 32'hBBBB;
    a_wd[0] = 32'h11;   a_wd[1] = 32'h22;
    b_rf[0] = 32'hCCCC; b_rf[1] = 32'hDDDD;
    b_wd[0] = 32'h111; b_wd[1] = 32'h222; b_wd[2] = 32'h333; b_wd[3] = 32'h444;
    b_iv = 1'b0; b_rd = '0; b_ld = 1'b0; b_rs = '0; b_kill = 1'b0;
    a_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);

    // reset state
    #2;
    chk("rst_stall", a_stall, 0);
    chk("rst_sel0",  a_sel[0], 0);
    chk("rst_sel1",  a_sel[1], 0);
    chk("rst_data0", a_data[0], 32'hAAAA);
    chk("rst_data1", a_data[1], 32'hBBBB);
    chk("rst_cnt",   a_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ALU result forwarded from stage 1
    a_issue(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("alu_issue_stall", a_stall, 0);
    tick();
    a_issue(1'b1, 5'd6, 1'b0, 5'd5, 5'd0, 1'b0);
    chk("alu_fwd_sel0",  a_sel[0], 1);
    chk("alu_fwd_data0", a_data[0], 32'h11);
    chk("alu_fwd_stall", a_stall, 0);
    chk("alu_fwd_sel1",  a_sel[1], 0);
    chk("alu_fwd_data1", a_data[1], 32'hBBBB);
    tick();  // stage1=rd6, stage2=rd5

    // load-use: one stall cycle, then forward from stage 2
    a_issue(1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();  // stage1=ld7, stage2=rd6
    a_issue(1'b1, 5'd8, 1'b0, 5'd6, 5'd7, 1'b0);
    chk("lu_stall",     a_stall, 1);
    chk("lu_sel1_s1",   a_sel[1], 1);
    chk("lu_sel0_s2",   a_sel[0], 2);
    chk("lu_data0_s2",  a_data[0], 32'h22);
    tick();  // stage1=bubble, stage2=ld7
    chk("lu_resolved",  a_stall, 0);
    chk("lu_sel1",      a_sel[1], 2);
    chk("lu_data1",     a_data[1], 32'h22);
    chk("lu_sel0_gone", a_sel[0], 0);
    chk("lu_cnt",       a_cnt, 1);
    tick();  // stage1=rd8
    chk("lu_cnt_hold",  a_cnt, 1);

    // youngest match wins; stall gating by valid and kill
    a_issue(1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    a_issue(1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();  // stage1=ld3, stage2=rd3
    a_issue(1'b0, 5'd10, 1'b0, 5'd3, 5'd0, 1'b0);
    chk("prio_sel0",    a_sel[0], 1);
    chk("prio_data0",   a_data[0], 32'h11);
    chk("noissue_stall", a_stall, 0);
    a_issue(1'b1, 5'd10, 1'b0, 5'd3, 5'd0, 1'b0);
    chk("prio_stall",   a_stall, 1);
    a_issue(1'b1, 5'd10, 1'b0, 5'd3, 5'd0, 1'b1);
    chk("kill_stall",   a_stall, 0);
    tick();  // killed: stage1=bubble, stage2=ld3
    a_issue(1'b1, 5'd10, 1'b0, 5'd3, 5'd0, 1'b0);
    chk("kill_bubble_sel", a_sel[0], 2);
    chk("kill_bubble_stall", a_stall, 0);
    chk("kill_cnt",     a_cnt, 1);

    // kill on a load-use stall inserts a bubble
    a_issue(1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();  // stage1=ld4
    a_issue(1'b1, 5'd11, 1'b0, 5'd4, 5'd0, 1'b1);
    chk("k4_stall",     a_stall, 0);
    tick();
    a_issue(1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 1'b0);
    chk("k4_bubble_sel", a_sel[0], 2);
    chk("k4_cnt",       a_cnt, 1);

    // x0 never forwards nor stalls
    a_issue(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();  // stage1 = valid load rd=0
    a_issue(1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("x0_sel0",  a_sel[0], 0);
    chk("x0_data0", a_data[0], 32'hAAAA);
    chk("x0_stall", a_stall, 0);

    // reset asserted in the middle of a stall
    a_issue(1'b1, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();  // stage1=ld12
    a_issue(1'b1, 5'd13, 1'b0, 5'd12, 5'd0, 1'b0);
    chk("mid_stall",    a_stall, 1);
    chk("mid_cnt_pre",  a_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_cnt",   a_cnt, 0);
    chk("mid_rst_sel0",  a_sel[0], 0);
    chk("mid_rst_data0", a_data[0], 32'hAAAA);
    a_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // deep pipe: load then dependent -> two stalls, then stage 3 forward
    b_iv = 1'b1; b_rd = 5'd9; b_ld = 1'b1; b_rs[0] = 5'd0; b_rs[1] = 5'd0;
    #1;
    chk("b_issue_stall", b_stall, 0);
    tick();
    b_rd = 5'd1; b_ld = 1'b0; b_rs[0] = 5'd9;
    #1;
    chk("b_stall1", b_stall, 1);
    chk("b_sel_s1", b_sel[0], 1);
    tick();
    chk("b_stall2", b_stall, 1);
    chk("b_sel_s2", b_sel[0], 2);
    chk("b_cnt1",   b_cnt, 1);
    tick();
    chk("b_free",   b_stall, 0);
    chk("b_sel_s3", b_sel[0], 3);
    chk("b_data",   b_data[0], 32'h333);
    chk("b_cnt2",   b_cnt, 2);
    b_iv = 1'b0;
    tick();
    chk("b_cnt_hold", b_cnt, 2);
    chk("a_cnt_idle", a_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
